multicycle_main_ctrl: RTL and testbench
=======================================

Name: multicycle_main_ctrl

Overview:
- Multicycle MIPS control unit; replaces the single-cycle main decoder.
- Sequences each instruction over FETCH/DECODE/execute/memory/writeback states and drives the shared-ALU/shared-memory datapath.
- Adds memory ready handshake, JR/JAL support, an illegal-op trap and an instruction-retired pulse.
- Sits between the instruction register (op/funct) and the datapath muxes/enables; ALU decoder consumes alu_operation.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1.
- ILLEGAL_TRAP, 1: 1 = unknown opcode enters HALT; 0 = unknown opcode returns to FETCH as NOP.
- STATE_W, 4: state register width; must be >= 4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- op  in  6  opcode from instruction register
- funct  in  6  function field; used only when op=000000
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- branch  out  1  conditional PC load (datapath ANDs with zero)
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (JR)
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- memtoreg  out  1  writeback from memory data register
- alu_src_a  out  1  0 PC, 1 A register
- alu_src_b  out  2  00 B, 01 const 4, 10 immediate, 11 immediate<<2
- alu_operation  out  2  00 add, 01 sub, 10 funct, 11 logic/LUI
- no_ext  out  1  zero-extend immediate
- jal  out  1  writeback data = PC (link)
- illegal_op  out  1  high while in HALT
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- state_o  out  STATE_W  current state, for debug

Behaviour:
- Sync reset: state <= FETCH; while rst_n=0, all strobes are forced 0: pc_write, branch, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op.
- Outputs are decoded combinationally from state; unlisted outputs are 0.
- Mealy exception: pc_write/ir_write in FETCH are gated by mem_ready.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_operation=00, pc_src=00, ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_operation=00 (branch target precompute).
  - Next state by op: LW/SW→MEMADR; 000000 with funct 001000→JR; other 000000→EXECUTE; BEQ→BRANCH; ADDI/ORI/LUI→IEXEC; J→JUMP; JAL→JALS.
  - Any other op → HALT (ILLEGAL_TRAP=1) or FETCH with instr_done=1 (ILLEGAL_TRAP=0).
- MEMADR: alu_src_a=1, alu_src_b=10, alu_operation=00; next MEMRD (LW) or MEMWR (SW).
- MEMRD: iord=1, mem_read=1; holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=00, memtoreg=1, instr_done=1; next FETCH.
- MEMWR: iord=1, mem_write=1; holds until mem_ready, then FETCH with instr_done=1 in the ready cycle. mem_write stays high across wait cycles.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_operation=10; next ALUWB.
- ALUWB: reg_write=1, reg_dst=01, instr_done=1; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_operation=01, branch=1, pc_src=01, instr_done=1; next FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10; next IWB.
  - ADDI: alu_operation=00.
  - ORI: alu_operation=11, no_ext=1.
  - LUI: alu_operation=11, no_ext=0.
- IWB: reg_write=1, reg_dst=00, instr_done=1; next FETCH. The op latched in the IR selects the IEXEC controls.
- JUMP: pc_write=1, pc_src=10, instr_done=1; next FETCH.
- JALS: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, jal=1, instr_done=1; next FETCH.
- JR: pc_write=1, pc_src=11, instr_done=1; next FETCH.
- HALT: illegal_op=1, all strobes 0; exits only on reset.
- Latency with zero wait states: LW 5, SW 4, R-type 4, ADDI/ORI/LUI 4, BEQ 3, J/JAL/JR 3 cycles. Each memory wait cycle adds 1.
- Reset asserted mid-instruction (including mid-wait): next state FETCH, no partial write strobe after the reset edge.
- Undefined state encodings recover to FETCH.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state enum/localparams.
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_LUI, OP_J, OP_JAL; FUNCT_JR.
  - alu_operation, pc_src, reg_dst and alu_src_b code constants.
- One sub-module, mc_ctrl_outdec: combinational state→control-word decoder. The FSM next-state logic and state register stay in the top.

Test Plan:
- Reset, then op=LW, MEM_HANDSHAKE=1, mem_ready low 2 cycles in FETCH and 1 in MEMRD → states FETCH×3, DECODE, MEMADR, MEMRD×2, MEMWB. reg_write=1, memtoreg=1 in MEMWB; instr_done pulses exactly once; 8 cycles total.
- op=000000 funct=100000, mem_ready=1 → FETCH, DECODE, EXECUTE (alu_operation=10), ALUWB (reg_dst=01, reg_write=1); 4 cycles.
- op=000000 funct=001000 → JR state with pc_src=11, pc_write=1, reg_write=0; op=000011 → JALS with reg_dst=10, jal=1, reg_write=1; both 3 cycles.
- op=001101 (ORI) → IEXEC with no_ext=1, alu_operation=11; op=001111 (LUI) → no_ext=0; both reach IWB with reg_dst=00.
- op=111111, ILLEGAL_TRAP=1 → HALT, illegal_op=1 held 20 cycles, no strobes; rst_n=0 → FETCH. With ILLEGAL_TRAP=0 → FETCH after DECODE with instr_done=1.
- SW held in MEMWR with mem_ready=0, rst_n=0 for 1 cycle → mem_write=0 during reset, state FETCH after the edge. With MEM_HANDSHAKE=0 and mem_ready tied 0, SW completes in 4 cycles.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_ctrl_pkg
// Purpose  : Shared definitions for the multicycle MIPS main control unit.
//            Contains the state encoding, opcode/funct constants, datapath
//            mux select codes and the packed control word produced by the
//            output decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Controller states. Encoding 4'd15 is unused and recovers to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11,
        S_JALS    = 4'd12,
        S_JR      = 4'd13,
        S_HALT    = 4'd14
    } state_e;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // alu_operation codes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    // pc_src codes
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    // reg_dst codes
    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    // alu_src_b codes
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Complete set of datapath controls for one cycle.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       memtoreg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_operation;
        logic       no_ext;
        logic       jal;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_word_t;

    // True for every opcode the controller knows how to sequence.
    function automatic logic is_known_op(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
            OP_ORI, OP_LUI, OP_J, OP_JAL: known = 1'b1;
            default:                      known = 1'b0;
        endcase
        return known;
    endfunction

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_outdec
// Purpose  : Combinational state -> control-word decoder for the multicycle
//            MIPS controller. Pure decode; reset gating is applied by the top.
// Ports    : state    in  STATE_W  current controller state
//            op       in  6        opcode held in the instruction register
//            mem_rdy  in  1        effective memory-ready (handshake resolved)
//            ctrl     out struct   decoded control word
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 1,
    parameter int STATE_W      = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic [5:0]         op,
    input  logic               mem_rdy,
    output ctrl_word_t         ctrl
);

    logic       w_upper_zero;
    logic [3:0] w_state_lo;

    // Any set bit above the 4-bit encoding marks an undefined state.
    generate
        if (STATE_W > 4) begin : g_wide_state
            assign w_upper_zero = ~|state[STATE_W-1:4];
        end else begin : g_narrow_state
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    assign w_state_lo = state[3:0];

    always_comb begin
        ctrl = '0;
        if (w_upper_zero) begin
            case (w_state_lo)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    // PC increment and IR load only once the fetch completes.
                    ctrl.ir_write  = mem_rdy;
                    ctrl.pc_write  = mem_rdy;
                end
                S_DECODE: begin
                    // Precompute the branch target while the opcode decodes.
                    ctrl.alu_src_b = SRCB_IMM_SH;
                    if (ILLEGAL_TRAP == 0 && !is_known_op(op)) begin
                        ctrl.instr_done = 1'b1;
                    end
                end
                S_MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    ctrl.iord     = 1'b1;
                    ctrl.mem_read = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_RT;
                    ctrl.memtoreg   = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.iord       = 1'b1;
                    ctrl.mem_write  = 1'b1;
                    ctrl.instr_done = mem_rdy;
                end
                S_EXECUTE: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_B;
                    ctrl.alu_operation = ALU_FUNCT;
                end
                S_ALUWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_RD;
                    ctrl.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_B;
                    ctrl.alu_operation = ALU_SUB;
                    ctrl.branch        = 1'b1;
                    ctrl.pc_src        = PC_ALUOUT;
                    ctrl.instr_done    = 1'b1;
                end
                S_IEXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    // ORI zero-extends; LUI shares the logic ALU path.
                    if (op == OP_ORI) begin
                        ctrl.alu_operation = ALU_LOGIC;
                        ctrl.no_ext        = 1'b1;
                    end else if (op == OP_LUI) begin
                        ctrl.alu_operation = ALU_LOGIC;
                    end else begin
                        ctrl.alu_operation = ALU_ADD;
                    end
                end
                S_IWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_RT;
                    ctrl.instr_done = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_src     = PC_JUMP;
                    ctrl.instr_done = 1'b1;
                end
                S_JALS: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_src     = PC_JUMP;
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_R31;
                    ctrl.jal        = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_JR: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_src     = PC_RS;
                    ctrl.instr_done = 1'b1;
                end
                S_HALT: begin
                    ctrl.illegal_op = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : mc_ctrl_outdec
`default_nettype wire

// File: rtl/multicycle_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_main_ctrl
// Purpose  : Multicycle MIPS main control FSM. Sequences each instruction
//            through fetch/decode/execute/memory/writeback and drives the
//            shared-ALU / shared-memory datapath controls.
// Ports    : clk, rst_n (sync, active-low)
//            op, funct          instruction register fields
//            mem_ready          memory access completes this cycle
//            pc_write..jal      datapath enables and mux selects
//            illegal_op         high while halted on an unknown opcode
//            instr_done         one-cycle pulse in an instruction's last cycle
//            state_o            current state, for debug
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_main_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ILLEGAL_TRAP  = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               branch,
    output logic [1:0]         pc_src,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic               memtoreg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_operation,
    output logic               no_ext,
    output logic               jal,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [STATE_W-1:0] state_o
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [3:0]         w_next_lo;
    logic               w_upper_zero;
    logic               w_mem_rdy;
    ctrl_word_t         w_ctrl_raw;
    ctrl_word_t         w_ctrl;

    generate
        if (MEM_HANDSHAKE != 0) begin : g_handshake
            assign w_mem_rdy = mem_ready;
        end else begin : g_no_handshake
            assign w_mem_rdy = 1'b1;
        end
    endgenerate

    generate
        if (STATE_W > 4) begin : g_wide_state
            assign w_upper_zero = ~|state_q[STATE_W-1:4];
        end else begin : g_narrow_state
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STATE_W'(S_FETCH);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; undefined encodings fall through to FETCH.
    always_comb begin
        w_next_lo = S_FETCH;
        if (w_upper_zero) begin
            case (state_q[3:0])
                S_FETCH:   w_next_lo = w_mem_rdy ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW:             w_next_lo = S_MEMADR;
                        OP_RTYPE:                 w_next_lo = (funct == FUNCT_JR) ? S_JR : S_EXECUTE;
                        OP_BEQ:                   w_next_lo = S_BRANCH;
                        OP_ADDI, OP_ORI, OP_LUI:  w_next_lo = S_IEXEC;
                        OP_J:                     w_next_lo = S_JUMP;
                        OP_JAL:                   w_next_lo = S_JALS;
                        default:                  w_next_lo = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
                    endcase
                end
                S_MEMADR:  w_next_lo = (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   w_next_lo = w_mem_rdy ? S_MEMWB : S_MEMRD;
                S_MEMWB:   w_next_lo = S_FETCH;
                S_MEMWR:   w_next_lo = w_mem_rdy ? S_FETCH : S_MEMWR;
                S_EXECUTE: w_next_lo = S_ALUWB;
                S_ALUWB:   w_next_lo = S_FETCH;
                S_BRANCH:  w_next_lo = S_FETCH;
                S_IEXEC:   w_next_lo = S_IWB;
                S_IWB:     w_next_lo = S_FETCH;
                S_JUMP:    w_next_lo = S_FETCH;
                S_JALS:    w_next_lo = S_FETCH;
                S_JR:      w_next_lo = S_FETCH;
                S_HALT:    w_next_lo = S_HALT;
                default:   w_next_lo = S_FETCH;
            endcase
        end
        state_d = STATE_W'(w_next_lo);
    end

    mc_ctrl_outdec #(
        .ILLEGAL_TRAP (ILLEGAL_TRAP),
        .STATE_W      (STATE_W)
    ) u_outdec (
        .state   (state_q),
        .op      (op),
        .mem_rdy (w_mem_rdy),
        .ctrl    (w_ctrl_raw)
    );

    // Output logic: while reset is held, every strobe is suppressed so that
    // no partial write escapes when reset lands mid-instruction.
    always_comb begin
        w_ctrl = w_ctrl_raw;
        if (!rst_n) begin
            w_ctrl.pc_write   = 1'b0;
            w_ctrl.branch     = 1'b0;
            w_ctrl.mem_read   = 1'b0;
            w_ctrl.mem_write  = 1'b0;
            w_ctrl.ir_write   = 1'b0;
            w_ctrl.reg_write  = 1'b0;
            w_ctrl.instr_done = 1'b0;
            w_ctrl.illegal_op = 1'b0;
        end
    end

    assign pc_write      = w_ctrl.pc_write;
    assign branch        = w_ctrl.branch;
    assign pc_src        = w_ctrl.pc_src;
    assign iord          = w_ctrl.iord;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_write     = w_ctrl.reg_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign memtoreg      = w_ctrl.memtoreg;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_operation = w_ctrl.alu_operation;
    assign no_ext        = w_ctrl.no_ext;
    assign jal           = w_ctrl.jal;
    assign illegal_op    = w_ctrl.illegal_op;
    assign instr_done    = w_ctrl.instr_done;
    assign state_o       = state_q;

endmodule : multicycle_main_ctrl
`default_nettype wire

// File: tb/tb_multicycle_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_main_ctrl
// Purpose  : Self-checking bench for multicycle_main_ctrl. Instance A uses the
//            default parameters; instance B has ILLEGAL_TRAP=0 and
//            MEM_HANDSHAKE=0 with mem_ready tied low.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic       rst_n, mem_ready;
    logic [5:0] op, funct;
    logic       pc_write, branch, iord, mem_read, mem_write, ir_write, reg_write;
    logic       memtoreg, alu_src_a, no_ext, jal, illegal_op, instr_done;
    logic [1:0] pc_src, reg_dst, alu_src_b, alu_operation;
    logic [3:0] state_o;

    // Instance B
    logic       b_rst_n;
    logic [5:0] b_op, b_funct;
    logic       b_pc_write, b_branch, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_write;
    logic       b_memtoreg, b_alu_src_a, b_no_ext, b_jal, b_illegal_op, b_instr_done;
    logic [1:0] b_pc_src, b_reg_dst, b_alu_src_b, b_alu_operation;
    logic [3:0] b_state_o;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_main_ctrl #(.MEM_HANDSHAKE(1), .ILLEGAL_TRAP(1), .STATE_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .memtoreg(memtoreg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_operation(alu_operation),
        .no_ext(no_ext), .jal(jal), .illegal_op(illegal_op),
        .instr_done(instr_done), .state_o(state_o)
    );

    multicycle_main_ctrl #(.MEM_HANDSHAKE(0), .ILLEGAL_TRAP(0), .STATE_W(4)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .op(b_op), .funct(b_funct), .mem_ready(1'b0),
        .pc_write(b_pc_write), .branch(b_branch), .pc_src(b_pc_src), .iord(b_iord),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
        .reg_write(b_reg_write), .reg_dst(b_reg_dst), .memtoreg(b_memtoreg),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_operation(b_alu_operation),
        .no_ext(b_no_ext), .jal(b_jal), .illegal_op(b_illegal_op),
        .instr_done(b_instr_done), .state_o(b_state_o)
    );

    // Expected non-strobe controls for a given phase of an instruction:
    // {pc_src, iord, reg_dst, memtoreg, alu_src_a, alu_src_b, alu_operation, no_ext, jal}
    function automatic logic [13:0] exp_fields(input state_e s, input logic [5:0] iop);
        logic [1:0] pcs, rdst, srcb, aop;
        logic       iord_e, m2r, srca, noext, jal_e;
        pcs = 2'b00; rdst = 2'b00; srcb = 2'b00; aop = 2'b00;
        iord_e = 1'b0; m2r = 1'b0; srca = 1'b0; noext = 1'b0; jal_e = 1'b0;
        case (s)
            S_FETCH:          srcb = 2'b01;
            S_DECODE:         srcb = 2'b11;
            S_MEMADR:         begin srca = 1'b1; srcb = 2'b10; end
            S_MEMRD, S_MEMWR: iord_e = 1'b1;
            S_MEMWB:          m2r = 1'b1;
            S_EXECUTE:        begin srca = 1'b1; aop = 2'b10; end
            S_ALUWB:          rdst = 2'b01;
            S_BRANCH:         begin pcs = 2'b01; srca = 1'b1; aop = 2'b01; end
            S_IEXEC: begin
                srca  = 1'b1;
                srcb  = 2'b10;
                aop   = (iop == OP_ADDI) ? 2'b00 : 2'b11;
                noext = (iop == OP_ORI);
            end
            S_JUMP:           pcs = 2'b10;
            S_JALS:           begin pcs = 2'b10; rdst = 2'b10; jal_e = 1'b1; end
            S_JR:             pcs = 2'b11;
            default:          ;
        endcase
        return {pcs, iord_e, rdst, m2r, srca, srcb, aop, noext, jal_e};
    endfunction

    // Runs one instruction on instance A (which must be in FETCH) with wf
    // fetch wait cycles and wm memory wait cycles, checking every cycle.
    task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                             input int wf, input int wm);
        state_e      seq[$];
        bit          rdy[$];
        bit          writes, jumps;
        int          last;
        logic [7:0]  exp_str, act_str;
        logic [13:0] exp_f, act_f;
        for (int k = 0; k < wf; k++) begin seq.push_back(S_FETCH); rdy.push_back(1'b0); end
        seq.push_back(S_FETCH);  rdy.push_back(1'b1);
        seq.push_back(S_DECODE); rdy.push_back(1'($urandom));
        case (iop)
            OP_LW: begin
                seq.push_back(S_MEMADR); rdy.push_back(1'($urandom));
                for (int k = 0; k < wm; k++) begin seq.push_back(S_MEMRD); rdy.push_back(1'b0); end
                seq.push_back(S_MEMRD); rdy.push_back(1'b1);
                seq.push_back(S_MEMWB); rdy.push_back(1'($urandom));
            end
            OP_SW: begin
                seq.push_back(S_MEMADR); rdy.push_back(1'($urandom));
                for (int k = 0; k < wm; k++) begin seq.push_back(S_MEMWR); rdy.push_back(1'b0); end
                seq.push_back(S_MEMWR); rdy.push_back(1'b1);
            end
            OP_RTYPE: begin
                if (ifn == FUNCT_JR) begin
                    seq.push_back(S_JR); rdy.push_back(1'($urandom));
                end else begin
                    seq.push_back(S_EXECUTE); rdy.push_back(1'($urandom));
                    seq.push_back(S_ALUWB);   rdy.push_back(1'($urandom));
                end
            end
            OP_BEQ: begin seq.push_back(S_BRANCH); rdy.push_back(1'($urandom)); end
            OP_ADDI, OP_ORI, OP_LUI: begin
                seq.push_back(S_IEXEC); rdy.push_back(1'($urandom));
                seq.push_back(S_IWB);   rdy.push_back(1'($urandom));
            end
            OP_J:   begin seq.push_back(S_JUMP); rdy.push_back(1'($urandom)); end
            OP_JAL: begin seq.push_back(S_JALS); rdy.push_back(1'($urandom)); end
            default: ;
        endcase
        writes = (iop == OP_LW) || (iop == OP_RTYPE && ifn != FUNCT_JR) || (iop == OP_ADDI)
              || (iop == OP_ORI) || (iop == OP_LUI) || (iop == OP_JAL);
        jumps  = (iop == OP_J) || (iop == OP_JAL) || (iop == OP_RTYPE && ifn == FUNCT_JR);
        last   = seq.size() - 1;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            op = iop; funct = ifn; mem_ready = rdy[i];
            #1;
            n_checks++;
            if (state_o !== 4'(seq[i]))
                $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d", iop, i, state_o, seq[i]);
            else n_pass++;
            // {pc_write, ir_write, mem_read, mem_write, reg_write, branch, instr_done, illegal_op}
            exp_str = {((seq[i] == S_FETCH) && rdy[i]) || (i == last && jumps),
                       (seq[i] == S_FETCH) && rdy[i],
                       (seq[i] == S_FETCH) || (seq[i] == S_MEMRD),
                       seq[i] == S_MEMWR,
                       (i == last) && writes,
                       (i == last) && (iop == OP_BEQ),
                       i == last,
                       1'b0};
            act_str = {pc_write, ir_write, mem_read, mem_write, reg_write, branch, instr_done, illegal_op};
            n_checks++;
            if (act_str !== exp_str)
                $display("FAIL strobes op=%b cyc=%0d got=%b exp=%b", iop, i, act_str, exp_str);
            else n_pass++;
            exp_f = exp_fields(seq[i], iop);
            act_f = {pc_src, iord, reg_dst, memtoreg, alu_src_a, alu_src_b, alu_operation, no_ext, jal};
            n_checks++;
            if (act_f !== exp_f)
                $display("FAIL fields op=%b cyc=%0d got=%b exp=%b", iop, i, act_f, exp_f);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1; op = OP_LW;
        #1;
        n_checks++;
        if ({pc_write, ir_write, mem_read, mem_write, reg_write, branch, instr_done, illegal_op} !== 8'b0)
            $display("FAIL reset_strobes got=%b exp=00000000",
                     {pc_write, ir_write, mem_read, mem_write, reg_write, branch, instr_done, illegal_op});
        else n_pass++;
        n_checks++;
        if (state_o !== 4'(S_FETCH)) $display("FAIL reset_state got=%0d exp=%0d", state_o, S_FETCH);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        n_checks++;
        if ({state_o, pc_write, mem_read} !== {4'(S_FETCH), 1'b0, 1'b1})
            $display("FAIL fetch_wait got=%b exp=%b", {state_o, pc_write, mem_read}, {4'(S_FETCH), 2'b01});
        else n_pass++;
    endtask

    task automatic test_lw_wait();
        run_instr(OP_LW, 6'b0, 2, 1);
    endtask

    task automatic test_rtype();
        run_instr(OP_RTYPE, 6'b100000, 0, 0);
    endtask

    task automatic test_jr_jal();
        run_instr(OP_RTYPE, FUNCT_JR, 0, 0);
        run_instr(OP_JAL, 6'b0, 0, 0);
        run_instr(OP_J, 6'b0, 0, 0);
        run_instr(OP_BEQ, 6'b0, 0, 0);
    endtask

    task automatic test_imm();
        run_instr(OP_ORI, 6'b0, 0, 0);
        run_instr(OP_LUI, 6'b0, 0, 0);
        run_instr(OP_ADDI, 6'b0, 1, 0);
    endtask

    task automatic test_random();
        logic [5:0] rop, rfn;
        for (int n = 0; n < 40; n++) begin
            rfn = 6'($urandom);
            case ($urandom_range(9, 0))
                0: rop = OP_LW;
                1: rop = OP_SW;
                2: begin rop = OP_RTYPE; if (rfn == FUNCT_JR) rfn = 6'b100000; end
                3: begin rop = OP_RTYPE; rfn = FUNCT_JR; end
                4: rop = OP_BEQ;
                5: rop = OP_ADDI;
                6: rop = OP_ORI;
                7: rop = OP_LUI;
                8: rop = OP_J;
                default: rop = OP_JAL;
            endcase
            run_instr(rop, rfn, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_sw_reset_midwait();
        logic [3:0] exp_s [4] = '{4'(S_FETCH), 4'(S_DECODE), 4'(S_MEMADR), 4'(S_MEMWR)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = OP_SW; mem_ready = (i == 0);
            #1;
            n_checks++;
            if (state_o !== exp_s[i]) $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", i, state_o, exp_s[i]);
            else n_pass++;
        end
        n_checks++;
        if ({mem_write, instr_done} !== 2'b10)
            $display("FAIL sw_wait got=%b exp=10", {mem_write, instr_done});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b0) $display("FAIL sw_reset_mem_write got=%b exp=0", mem_write);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({state_o, mem_write} !== {4'(S_FETCH), 1'b0})
            $display("FAIL sw_after_reset got=%b exp=%b", {state_o, mem_write}, {4'(S_FETCH), 1'b0});
        else n_pass++;
    endtask

    task automatic test_illegal_trap();
        @(negedge clk); op = 6'b111111; mem_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({state_o, instr_done} !== {4'(S_DECODE), 1'b0})
            $display("FAIL trap_decode got=%b exp=%b", {state_o, instr_done}, {4'(S_DECODE), 1'b0});
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            #1;
            n_checks++;
            if ({state_o, illegal_op, pc_write, ir_write, mem_read, mem_write, reg_write, branch, instr_done}
                !== {4'(S_HALT), 8'b1000_0000})
                $display("FAIL halt cyc=%0d got=%b exp=%b", i,
                         {state_o, illegal_op, pc_write, ir_write, mem_read, mem_write, reg_write, branch, instr_done},
                         {4'(S_HALT), 8'b1000_0000});
            else n_pass++;
        end
        @(negedge clk); rst_n = 1'b0; #1;
        n_checks++;
        if (illegal_op !== 1'b0) $display("FAIL halt_reset_illegal got=%b exp=0", illegal_op);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
        n_checks++;
        if ({state_o, illegal_op} !== {4'(S_FETCH), 1'b0})
            $display("FAIL halt_exit got=%b exp=%b", {state_o, illegal_op}, {4'(S_FETCH), 1'b0});
        else n_pass++;
    endtask

    task automatic test_notrap();
        logic [3:0] exp_s [3] = '{4'(S_FETCH), 4'(S_DECODE), 4'(S_FETCH)};
        logic       exp_d [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_rst_n = 1'b1; b_op = 6'b111111;
            #1;
            n_checks++;
            if ({b_state_o, b_instr_done, b_illegal_op} !== {exp_s[i], exp_d[i], 1'b0})
                $display("FAIL notrap cyc=%0d got=%b exp=%b", i,
                         {b_state_o, b_instr_done, b_illegal_op}, {exp_s[i], exp_d[i], 1'b0});
            else n_pass++;
        end
        @(negedge clk); b_rst_n = 1'b0;
    endtask

    task automatic test_no_handshake_sw();
        logic [3:0] exp_s [5] = '{4'(S_FETCH), 4'(S_DECODE), 4'(S_MEMADR), 4'(S_MEMWR), 4'(S_FETCH)};
        logic [2:0] exp_v [5] = '{3'b100, 3'b000, 3'b000, 3'b011, 3'b100};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_rst_n = 1'b1; b_op = OP_SW;
            #1;
            // {pc_write, mem_write, instr_done}
            n_checks++;
            if ({b_state_o, b_pc_write, b_mem_write, b_instr_done} !== {exp_s[i], exp_v[i]})
                $display("FAIL nohs_sw cyc=%0d got=%b exp=%b", i,
                         {b_state_o, b_pc_write, b_mem_write, b_instr_done}, {exp_s[i], exp_v[i]});
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; b_rst_n = 1'b0;
        op = 6'b0; funct = 6'b0; mem_ready = 1'b0;
        b_op = 6'b0; b_funct = 6'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_lw_wait();
        test_rtype();
        test_jr_jal();
        test_imm();
        test_sw_reset_midwait();
        test_random();
        test_illegal_trap();
        test_notrap();
        test_no_handshake_sw();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_multicycle_main_ctrl
`default_nettype wire
